// File: rtl/vx_fetch_ibuf_pkg.sv
// Shared types for the fetch instruction buffer slice.
//   NUM_WARPS_DEF : default warp count for this build
//   NW_WIDTH      : warp-id width, at least 1 bit
//   UUID_WIDTH    : instruction uuid width
//   fetch_t       : fetch packet {uuid, wid, tmask, PC, instr}
// These mirror the GPU-wide definitions so the slice builds on its own.
package vx_fetch_ibuf_pkg;

  localparam int NUM_WARPS_DEF = 4;
  localparam int NUM_THREADS   = 4;
  localparam int UUID_WIDTH    = 32;
  localparam int NW_WIDTH      = (NUM_WARPS_DEF > 1) ? $clog2(NUM_WARPS_DEF) : 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            PC;
    logic [31:0]            instr;
  } fetch_t;

endpackage

// File: rtl/vx_fetch_ibuf_if.sv
// Valid/ready handshake carrying one fetch_t packet.
//   valid : producer has a packet
//   data  : the packet
//   ready : consumer accepts this cycle
// master = producer side, slave = consumer side.
interface vx_fetch_ibuf_if;
  import vx_fetch_ibuf_pkg::*;

  logic   valid;
  fetch_t data;
  logic   ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_ibuf_warp_fifo.sv
// Single-warp instruction FIFO.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, read from registered storage
//   empty/full : occupancy flags
module vx_ibuf_warp_fifo
  import vx_fetch_ibuf_pkg::*;
#(
  parameter int IBUF_SIZE = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  fetch_t wdata,
  input  logic   pop,
  output fetch_t rdata,
  output logic   empty,
  output logic   full
);

  localparam int AW = $clog2(IBUF_SIZE);

  fetch_t         mem [IBUF_SIZE];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(IBUF_SIZE));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because IBUF_SIZE is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vx_fetch_ibuf.sv
// Per-warp instruction buffer between fetch and decode.
//   clk, reset : clock, synchronous active-high reset
//   fetch      : slave handshake from fetch; ready = ~full[fetch.data.wid]
//   decode     : master handshake to decode; one instruction per cycle,
//                round-robin over non-empty warps, grant frozen while stalled
//   ibuf_pop   : registered one-hot credit, bit w pulses the cycle after
//                warp w is dequeued
module vx_fetch_ibuf
  import vx_fetch_ibuf_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int IBUF_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_fetch_ibuf_if.slave       fetch,
  vx_fetch_ibuf_if.master      decode,
  output logic [NUM_WARPS-1:0] ibuf_pop
);

  logic [NUM_WARPS-1:0] empty;
  logic [NUM_WARPS-1:0] full;
  logic [NUM_WARPS-1:0] push;
  logic [NUM_WARPS-1:0] pop;
  fetch_t               head [NUM_WARPS];

  logic [NW_WIDTH-1:0]  last_grant;
  logic [NW_WIDTH-1:0]  lock_wid;
  logic                 lock_vld;
  logic [NW_WIDTH-1:0]  grant;
  logic                 any_valid;
  logic                 handshake;

  // Nearest requester after `last` wins; scanning from the far end lets the
  // closest hit overwrite the result without an early exit.
  function automatic logic [NW_WIDTH-1:0] rr_pick(
    input logic [NW_WIDTH-1:0]  last,
    input logic [NUM_WARPS-1:0] req
  );
    logic [NW_WIDTH-1:0] pick;
    int                  idx;
    pick = last;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_WARPS;
      if (req[idx]) pick = NW_WIDTH'(idx);
    end
    return pick;
  endfunction

  // Full warps are refused outright, even when popped this cycle.
  assign fetch.ready = ~full[fetch.data.wid];

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w] = fetch.valid && fetch.ready && (fetch.data.wid == NW_WIDTH'(w));
    assign pop[w]  = handshake && (grant == NW_WIDTH'(w));

    vx_ibuf_warp_fifo #(
      .IBUF_SIZE (IBUF_SIZE)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[w]),
      .wdata (fetch.data),
      .pop   (pop[w]),
      .rdata (head[w]),
      .empty (empty[w]),
      .full  (full[w])
    );
  end

  // Grant selection: all inputs are registered state, so fetch never reaches
  // decode combinationally. A locked warp is still non-empty because it was
  // not popped.
  always_comb begin
    grant     = lock_vld ? lock_wid : rr_pick(last_grant, ~empty);
    any_valid = lock_vld || (|(~empty));
    handshake = any_valid && decode.ready;
  end

  assign decode.valid = any_valid;
  assign decode.data  = head[grant];

  // Registered grant lock, round-robin pointer and credit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= NW_WIDTH'(NUM_WARPS - 1);
      lock_vld   <= 1'b0;
      lock_wid   <= '0;
      ibuf_pop   <= '0;
    end else begin
      lock_vld <= any_valid && !decode.ready;
      lock_wid <= grant;
      ibuf_pop <= '0;
      if (handshake) begin
        last_grant      <= grant;
        ibuf_pop[grant] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_fetch_ibuf.sv
// Scoreboard bench for vx_fetch_ibuf: per-warp expected queues are filled on
// accepted fetch handshakes and drained/compared on decode handshakes.
module tb_vx_fetch_ibuf;
  import vx_fetch_ibuf_pkg::*;

  localparam int NW    = NUM_WARPS_DEF;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] ibuf_pop;

  vx_fetch_ibuf_if fetch_bus ();
  vx_fetch_ibuf_if decode_bus ();

  vx_fetch_ibuf #(
    .NUM_WARPS (NW),
    .IBUF_SIZE (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch    (fetch_bus),
    .decode   (decode_bus),
    .ibuf_pop (ibuf_pop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  fetch_t        sb_q [NW][$];
  int            m_last = NW - 1;
  bit            m_lock = 1'b0;
  int            m_lock_wid = 0;
  logic [NW-1:0] m_pop = '0;
  int            hs_count = 0;
  int            grant_log [$];
  int            pop_log [$];

  function automatic int tb_pick(input int last, input logic [NW-1:0] nonempty);
    int r;
    int c;
    r = -1;
    for (int k = 1; k <= NW; k++) begin
      c = (last + k) % NW;
      if (r < 0 && nonempty[c]) r = c;
    end
    return r;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin : monitor
    logic [NW-1:0] nonempty;
    bit            exp_dv;
    bit            ready_exp;
    bit            hs;
    int            gw;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int w = 0; w < NW; w++) sb_q[w].delete();
        m_last = NW - 1;
        m_lock = 1'b0;
        m_pop  = '0;
      end else begin
        for (int w = 0; w < NW; w++) nonempty[w] = (sb_q[w].size() > 0);
        exp_dv = m_lock || (|nonempty);
        check_val("decode_valid", decode_bus.valid, exp_dv);
        check_val("ibuf_pop", ibuf_pop, m_pop);
        if (ibuf_pop != '0) pop_log.push_back(int'(ibuf_pop));
        gw = m_lock ? m_lock_wid : tb_pick(m_last, nonempty);
        if (exp_dv) begin
          check_val("grant_wid", decode_bus.data.wid, gw);
          check_val("sb_entry", sb_q[gw].size() > 0, 1'b1);
          if (sb_q[gw].size() > 0) check_val("decode_data", decode_bus.data, sb_q[gw][0]);
        end
        ready_exp = 1'b0;
        if (fetch_bus.valid) begin
          ready_exp = (sb_q[fetch_bus.data.wid].size() < DEPTH);
          check_val("fetch_ready", fetch_bus.ready, ready_exp);
        end
        hs = exp_dv && decode_bus.valid && decode_bus.ready;
        m_pop = '0;
        if (hs) begin
          grant_log.push_back(int'(decode_bus.data.wid));
          if (sb_q[gw].size() > 0) void'(sb_q[gw].pop_front());
          m_last    = gw;
          m_pop[gw] = 1'b1;
          hs_count++;
        end
        m_lock     = exp_dv && !decode_bus.ready;
        m_lock_wid = gw;
        if (fetch_bus.valid && ready_exp) sb_q[fetch_bus.data.wid].push_back(fetch_bus.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input bit v, input int wid, input logic [31:0] pc);
    fetch_bus.valid      = v;
    fetch_bus.data.uuid  = pc ^ 32'h5a5a_0000;
    fetch_bus.data.wid   = NW_WIDTH'(wid);
    fetch_bus.data.tmask = NUM_THREADS'(wid + 1);
    fetch_bus.data.PC    = pc;
    fetch_bus.data.instr = ~pc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_ready(input string tag);
    for (int w = 0; w < NW; w++) begin
      fetch_bus.data.wid = NW_WIDTH'(w);
      #1;
      check_val(tag, fetch_bus.ready, 1'b1);
    end
  endtask

  task automatic drain(input string tag);
    decode_bus.ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!decode_bus.valid) break;
    end
    check_val(tag, decode_bus.valid, 1'b0);
    tick();
    decode_bus.ready = 1'b0;
  endtask

  initial begin : stim
    int order [6];
    int base;
    order = '{0, 1, 3, 0, 1, 3};
    set_fetch(1'b0, 0, 32'h0);
    decode_bus.ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_decode_valid", decode_bus.valid, 1'b0);
    check_val("rst_ibuf_pop", ibuf_pop, '0);
    check_all_ready("rst_fetch_ready");

    // Single packet to warp 2
    tick();
    set_fetch(1'b1, 2, 32'h8000_0000);
    tick();
    set_fetch(1'b0, 0, 32'h0);
    check_val("single_valid", decode_bus.valid, 1'b1);
    check_val("single_pc", decode_bus.data.PC, 32'h8000_0000);
    check_val("single_wid", decode_bus.data.wid, 2);
    decode_bus.ready = 1'b1;
    tick();
    decode_bus.ready = 1'b0;
    check_val("single_pop", ibuf_pop, 4'b0100);
    tick();
    check_val("single_pop_clear", ibuf_pop, 4'b0000);
    check_val("single_empty", decode_bus.valid, 1'b0);

    // Fill warp 1, then a refused push alongside a pop
    for (int i = 0; i < DEPTH; i++) begin
      set_fetch(1'b1, 1, 32'h0000_2000 + 32'(4 * i));
      tick();
    end
    set_fetch(1'b0, 1, 32'h0);
    #1;
    check_val("full_w1_ready", fetch_bus.ready, 1'b0);
    fetch_bus.data.wid = NW_WIDTH'(0);
    #1;
    check_val("full_w0_ready", fetch_bus.ready, 1'b1);
    set_fetch(1'b1, 1, 32'h0000_2010);
    decode_bus.ready = 1'b1;
    #1;
    check_val("no_pop_through", fetch_bus.ready, 1'b0);
    tick();
    set_fetch(1'b0, 0, 32'h0);
    drain("w1_drained");

    // Round-robin order over warps 0,1,3
    pulse_reset();
    tick();
    for (int i = 0; i < 6; i++) begin
      set_fetch(1'b1, order[i], 32'h0000_3000 + 32'(16 * i));
      tick();
    end
    set_fetch(1'b0, 0, 32'h0);
    grant_log.delete();
    pop_log.delete();
    drain("rr_drained");
    tick();
    check_val("rr_grant_count", grant_log.size(), 6);
    check_val("rr_pop_count", pop_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check_val("rr_grant_order", grant_log[i], order[i]);
      if (i < pop_log.size())   check_val("rr_pop_order", pop_log[i], 1 << order[i]);
    end

    // Grant lock: warp 3 stalled, warp 0 arrives behind it
    set_fetch(1'b1, 3, 32'h0000_4000);
    tick();
    set_fetch(1'b1, 0, 32'h0000_4100);
    tick();
    set_fetch(1'b0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check_val("lock_wid_held", decode_bus.data.wid, 3);
      tick();
    end
    decode_bus.ready = 1'b1;
    tick();
    check_val("after_lock_valid", decode_bus.valid, 1'b1);
    check_val("after_lock_wid", decode_bus.data.wid, 0);
    tick();
    decode_bus.ready = 1'b0;
    check_val("after_lock_empty", decode_bus.valid, 1'b0);

    // Streaming 100 packets through warp 0
    decode_bus.ready = 1'b1;
    base = hs_count;
    for (int i = 0; i < 100; i++) begin
      set_fetch(1'b1, 0, 32'h0001_0000 + 32'(4 * i));
      tick();
      check_val("stream_valid", decode_bus.valid, 1'b1);
    end
    set_fetch(1'b0, 0, 32'h0);
    tick();
    @(negedge clk);
    check_val("stream_count", hs_count - base, 100);
    check_val("stream_done", decode_bus.valid, 1'b0);
    tick();
    decode_bus.ready = 1'b0;

    // Reset with entries buffered and a dequeue coinciding with reset
    set_fetch(1'b1, 0, 32'h0000_5000);
    tick();
    set_fetch(1'b1, 1, 32'h0000_5004);
    tick();
    set_fetch(1'b1, 2, 32'h0000_5008);
    tick();
    set_fetch(1'b1, 3, 32'h0000_500c);
    decode_bus.ready = 1'b1;
    tick();
    set_fetch(1'b0, 0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    decode_bus.ready = 1'b0;
    check_val("mid_rst_valid", decode_bus.valid, 1'b0);
    check_val("mid_rst_pop", ibuf_pop, '0);
    check_all_ready("mid_rst_ready");
    tick();
    check_val("post_rst_pop", ibuf_pop, '0);
    check_val("post_rst_valid", decode_bus.valid, 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
